// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - time-multiplexed FIR: one signed MAC sequenced over N taps per sample
// Optional macro FIR_SCHED_SAT_EN: saturate (rather than wrap) when OUT_W < ACC_W.
module fir_mac_scheduler #(
  parameter  int N      = 4,
  parameter  int WIDTH  = 8,
  parameter  int CWIDTH = 8,
  parameter  int OUT_W  = 20,
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1,
  localparam int ACC_W  = WIDTH + CWIDTH + $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  in_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_sample,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [CWIDTH-1:0] coef_data,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                          state_q;
  logic signed [WIDTH-1:0]         x_q    [N];
  logic signed [CWIDTH-1:0]        coef_q [N];
  logic [ADDR_W-1:0]               tap_q;
  logic signed [ACC_W-1:0]         acc_q;
  logic signed [ACC_W-1:0]         acc_d;
  logic signed [WIDTH+CWIDTH-1:0]  prod;
  logic signed [OUT_W-1:0]         result_d;

  assign prod  = x_q[tap_q] * coef_q[tap_q];
  assign acc_d = acc_q + ACC_W'(prod);

  // Final sum narrowed to the output width; only the narrowing case needs a policy.
  generate
    if (OUT_W >= ACC_W) begin : g_extend
      assign result_d = OUT_W'(acc_d);
    end else begin : g_narrow
`ifdef FIR_SCHED_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      assign result_d = (acc_d > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                        (acc_d < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : acc_d[OUT_W-1:0];
`else
      assign result_d = acc_d[OUT_W-1:0];
`endif
    end
  endgenerate

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tap_q      <= '0;
      acc_q      <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      for (int k = 0; k < N; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= CWIDTH'(1);
      end
    end else begin
      // Coefficients are frozen while the MAC walks the taps.
      if (coef_we && state_q != MAC && int'(coef_addr) < N)
        coef_q[coef_addr] <= coef_data;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q[0] <= in_sample;
            for (int k = 1; k < N; k++)
              x_q[k] <= x_q[k-1];
            acc_q   <= '0;
            tap_q   <= '0;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + ADDR_W'(1);
          if (tap_q == ADDR_W'(N-1)) begin
            out_sample <= result_d;
            out_valid  <= 1'b1;
            tap_q      <= '0;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
